uart_tx_drain: RTL and testbench
================================

Name: uart_tx_drain

Overview:
- Transmit-side UART serializer that sits directly downstream of the transmit byte FIFO.
- Pops one word at a time from the FIFO read port whenever the FIFO is non-empty.
- Frames each word as start bit, DATA_WIDTH data bits LSB first, optional parity, then STOP_BITS stop bits, and drives the serial line.
- Baud timing comes from an internal clock-cycles-per-bit counter; the block needs no external baud strobe.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and the number of data bits per frame (5..9).
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
- STOP_BITS, 1, number of stop bits (1 or 2).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clock, input, 1, single system clock; all state updates on its rising edge.
- resetn, input, 1, synchronous active-low reset.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_data, input, DATA_WIDTH, FIFO read data; registered, valid the cycle after a pop.
- fifo_pop, output, 1, one-cycle FIFO read request.
- tx, output, 1, serial line; idles high.
- busy, output, 1, high whenever the block is outside IDLE.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-low, sampled at the rising edge of clock.
  - While resetn=0: state=IDLE, tx=1, busy=0, bit and baud counters cleared, and fifo_pop is forced to 0.
- Output timing:
  - tx and busy are registered; tx never glitches.
  - fifo_pop is a combinational decode of state and fifo_empty, gated by resetn.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0: fifo_pop=1 for this cycle, next state FETCH.
  - Otherwise remain in IDLE with fifo_pop=0.
- FETCH (exactly 1 cycle):
  - tx=1; fifo_data is latched into the shift register; parity bit is computed.
  - Next state START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - DATA_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit counter runs 0..DATA_WIDTH-1.
- PARITY:
  - Present only when PARITY!=0; held for CLKS_PER_BIT cycles.
  - Even mode sends the XOR of the data bits; odd mode sends its inverse.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - In the final cycle of the last stop bit:
    - fifo_empty=0: fifo_pop=1, next state FETCH (back-to-back frame).
    - Otherwise next state IDLE.
- Latency: if fifo_empty=0 is sampled in IDLE in cycle N, fifo_pop=1 in cycle N and tx falls at the edge ending cycle N+1. tx is low during cycle N+2.
- Back-to-back frame period: 1 + (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS)*CLKS_PER_BIT cycles, measured start-edge to start-edge. The extra cycle is FETCH with tx=1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Width is clog2(CLKS_PER_BIT).
- Pop rules:
  - Exactly one pop per transmitted frame.
  - fifo_pop is never asserted while fifo_empty=1.
  - fifo_pop is never asserted outside IDLE or the last STOP cycle.
- fifo_empty rising mid-frame has no effect on the frame in flight.
- Reset mid-frame:
  - The frame is aborted and tx=1 from the next edge.
  - The in-flight word is lost; no re-pop and no further pops while resetn=0.
- busy=1 from FETCH through the end of STOP. It is 0 only in IDLE.

Test Plan:
- Reset check: hold resetn=0 for 3 cycles with fifo_empty=0 -> fifo_pop=0, tx=1 and busy=0 every cycle; after release, the first pop occurs in the first cycle with resetn=1.
- Single byte (CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1):
  - Stimulus: FIFO holds 0xA5 only.
  - Response: exactly one pop; tx shows 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; tx falls at pop cycle + 2.
  - Afterwards: busy drops and the block stays in IDLE.
- Back-to-back: FIFO holds 0x00 then 0xFF -> two pops 41 cycles apart; start-bit falling edges 41 cycles apart; exactly 1 FETCH cycle of tx=1 between the stop bit and the second start bit.
- Parity (PARITY=1, then PARITY=2):
  - Stimulus: send 0x07 in each mode.
  - Response: parity bit is 1 in even mode and 0 in odd mode, held 4 cycles between data bit 7 and the stop bit.
- Empty hold: fifo_empty=1 for 100 cycles -> fifo_pop=0, tx=1, busy=0 throughout.
- Mid-frame reset: pulse resetn=0 for 1 cycle during data bit 3 of 0x3C -> tx=1 from the next edge; no pop during reset; the next FIFO word transmits as a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - UART transmit serializer draining a registered-output byte FIFO
// Frames each popped word as start, data (LSB first), optional parity and stop bits.
module uart_tx_drain #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY       = 0
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_pop,
   output logic                  tx,
   output logic                  busy
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t                state, state_d;
   logic [BW-1:0]         baud_cnt, baud_d;
   logic [CW-1:0]         bit_cnt, bit_d;
   logic [DATA_WIDTH-1:0] shreg, shreg_d;
   logic                  par_bit, par_d;
   logic                  pop_raw;
   logic                  tx_d;
   logic                  baud_last;

   always_comb begin
      state_d   = state;
      baud_d    = baud_cnt;
      bit_d     = bit_cnt;
      shreg_d   = shreg;
      par_d     = par_bit;
      pop_raw   = 1'b0;
      baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));

      if (state != S_IDLE && state != S_FETCH)
         baud_d = baud_last ? '0 : baud_cnt + BW'(1);

      case (state)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!fifo_empty) begin
               pop_raw = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            // fifo_data is the registered read data for the pop of the previous cycle
            shreg_d = fifo_data;
            par_d   = (^fifo_data) ^ (PARITY == 2);
            baud_d  = '0;
            bit_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            if (baud_last) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d   = bit_cnt + CW'(1);
                  shreg_d = shreg >> 1;
               end
            end
         end
         S_PARITY: begin
            if (baud_last) begin
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               if (bit_cnt == CW'(STOP_BITS - 1)) begin
                  // last stop cycle: chain straight into the next frame if data waits
                  if (!fifo_empty) begin
                     pop_raw = 1'b1;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_cnt + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   assign fifo_pop = resetn & pop_raw;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_d;
         bit_cnt  <= bit_d;
         shreg    <= shreg_d;
         par_bit  <= par_d;
         tx       <= tx_d;
         busy     <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - directed self-checking bench for uart_tx_drain
// Three instances at 4 clocks per bit: no parity (FIFO model), even parity, odd parity.
module tb_uart_tx_drain;

   logic       clock;
   logic       resetn;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_pop;
   logic       tx;
   logic       busy;

   logic       fifo_empty_p;
   logic [7:0] pdata;
   logic       fifo_pop_e, tx_e, busy_e;
   logic       fifo_pop_o, tx_o, busy_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;

   logic tx_tr   [0:4095];
   logic busy_tr [0:4095];
   logic txe_tr  [0:4095];
   logic txo_tr  [0:4095];
   int   pop_cyc [0:63];
   int   fall_cyc[0:63];
   int   npop = 0;
   int   nfall = 0;
   int   pop_empty = 0;
   logic tx_prev = 1'b1;

   uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY(0)) dut (
      .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_pop(fifo_pop), .tx(tx), .busy(busy));

   uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY(1)) dut_e (
      .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty_p), .fifo_data(pdata),
      .fifo_pop(fifo_pop_e), .tx(tx_e), .busy(busy_e));

   uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY(2)) dut_o (
      .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty_p), .fifo_data(pdata),
      .fifo_pop(fifo_pop_o), .tx(tx_o), .busy(busy_o));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // FIFO model with registered read data
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clock) begin
      if (fifo_pop) begin
         fifo_data <= mem[rd_ptr % 16];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   always @(negedge clock) begin
      if (cyc < 4096) begin
         tx_tr[cyc]   = tx;
         busy_tr[cyc] = busy;
         txe_tr[cyc]  = tx_e;
         txo_tr[cyc]  = tx_o;
      end
      if (fifo_pop === 1'b1) begin
         if (npop < 64) pop_cyc[npop] = cyc;
         npop++;
         if (fifo_empty) pop_empty++;
      end
      if (tx_prev === 1'b1 && tx === 1'b0) begin
         if (nfall < 64) fall_cyc[nfall] = cyc;
         nfall++;
      end
      tx_prev = tx;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] nib(input int sel, input int f);
      logic [3:0] r;
      r = 4'hx;
      if (f >= 0 && f + 3 < 4096) begin
         for (int k = 0; k < 4; k++) begin
            case (sel)
               1:       r[3-k] = txe_tr[f+k];
               2:       r[3-k] = txo_tr[f+k];
               default: r[3-k] = tx_tr[f+k];
            endcase
         end
      end
      return r;
   endfunction

   task automatic check_frame(input string tag, input int f, input logic [0:9] pat);
      for (int i = 0; i < 10; i++)
         chk($sformatf("%s_bit%0d", tag, i), {28'd0, nib(0, f + 4*i)}, {28'd0, {4{pat[i]}}});
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 16] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   initial begin
      int b, fb, p, f1, f2, viol;
      logic [0:9] pat_a5, pat_96;
      pat_a5 = 10'b0101001011;
      pat_96 = 10'b0011010011;
      pdata = 8'h07;
      fifo_empty_p = 1'b1;
      resetn = 1'b0;
      push(8'hA5);

      // reset held with data waiting
      repeat (3) begin
         @(negedge clock);
         chk("rst_pop", {31'd0, fifo_pop}, 32'd0);
         chk("rst_tx", {31'd0, tx}, 32'd1);
         chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      @(posedge clock); #1 resetn = 1'b1;
      @(negedge clock);
      chk("first_pop", {31'd0, fifo_pop}, 32'd1);
      repeat (60) @(posedge clock);

      chk("a5_npop", npop, 1);
      chk("a5_latency", fall_cyc[0] - pop_cyc[0], 2);
      check_frame("a5", fall_cyc[0], pat_a5);
      chk("a5_busy_fetch", {31'd0, busy_tr[pop_cyc[0] + 1]}, 32'd1);
      chk("a5_busy_stop", {31'd0, busy_tr[fall_cyc[0] + 39]}, 32'd1);
      chk("a5_busy_idle", {31'd0, busy_tr[fall_cyc[0] + 40]}, 32'd0);

      // back-to-back 0x00, 0xFF
      @(posedge clock); #1;
      b = npop; fb = nfall;
      push(8'h00); push(8'hFF);
      repeat (110) @(posedge clock);
      chk("b2b_npop", npop - b, 2);
      chk("b2b_pop_gap", pop_cyc[b+1] - pop_cyc[b], 41);
      chk("b2b_nfall", nfall - fb, 2);
      f1 = fall_cyc[fb]; f2 = fall_cyc[fb+1];
      chk("b2b_fall_gap", f2 - f1, 41);
      chk("b2b_last_data", {31'd0, tx_tr[f1 + 35]}, 32'd0);
      chk("b2b_fetch_tx", {31'd0, tx_tr[f2 - 1]}, 32'd1);
      chk("b2b_fetch_busy", {31'd0, busy_tr[f2 - 1]}, 32'd1);
      chk("b2b_ff_bit0", {28'd0, nib(0, f2 + 4)}, 32'hF);
      chk("b2b_idle", {31'd0, busy_tr[f2 + 40]}, 32'd0);

      // empty hold
      viol = 0;
      repeat (100) begin
         @(negedge clock);
         if (fifo_pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      chk("empty_hold", viol, 0);

      // reset pulse during data bit 3 of 0x3C
      @(posedge clock); #1;
      b = npop; fb = nfall; p = cyc;
      push(8'h3C);
      repeat (10) @(posedge clock); #1;
      push(8'h96);
      repeat (9) @(posedge clock); #1;
      resetn = 1'b0;
      @(negedge clock);
      chk("mid_rst_nopop", {31'd0, fifo_pop}, 32'd0);
      @(posedge clock); #1 resetn = 1'b1;
      repeat (60) @(posedge clock);
      chk("mid_first_pop", pop_cyc[b], p);
      chk("mid_tx_hi", {31'd0, tx_tr[p + 20]}, 32'd1);
      chk("mid_busy_lo", {31'd0, busy_tr[p + 20]}, 32'd0);
      chk("mid_npop", npop - b, 2);
      chk("mid_repop_cyc", pop_cyc[b+1], p + 20);
      chk("mid_fall", fall_cyc[fb+1], p + 22);
      check_frame("x96", fall_cyc[fb+1], pat_96);

      // parity: 0x07 has odd weight
      @(posedge clock); #1;
      p = cyc;
      fifo_empty_p = 1'b0;
      @(negedge clock);
      chk("par_e_pop", {31'd0, fifo_pop_e}, 32'd1);
      chk("par_o_pop", {31'd0, fifo_pop_o}, 32'd1);
      @(posedge clock); #1 fifo_empty_p = 1'b1;
      repeat (55) @(posedge clock);
      chk("par_e_start", {28'd0, nib(1, p + 2)}, 32'h0);
      chk("par_e_d0", {28'd0, nib(1, p + 6)}, 32'hF);
      chk("par_e_d7", {28'd0, nib(1, p + 34)}, 32'h0);
      chk("par_e_par", {28'd0, nib(1, p + 38)}, 32'hF);
      chk("par_e_stop", {28'd0, nib(1, p + 42)}, 32'hF);
      chk("par_o_start", {28'd0, nib(2, p + 2)}, 32'h0);
      chk("par_o_d7", {28'd0, nib(2, p + 34)}, 32'h0);
      chk("par_o_par", {28'd0, nib(2, p + 38)}, 32'h0);
      chk("par_o_stop", {28'd0, nib(2, p + 42)}, 32'hF);
      @(negedge clock);
      chk("par_e_idle", {31'd0, busy_e}, 32'd0);
      chk("par_o_idle", {31'd0, busy_o}, 32'd0);

      chk("pop_when_empty", pop_empty, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
